board_datapath: RTL
===================

Name: board_datapath

Overview:
Owns all writes to the shared 64-entry board memory (8x8 squares, 4-bit piece code per square).
- On `initialize_board`, writes the opening layout to every square, then pulses `initialize_complete`.
- On `move_piece`, clears the origin square, writes `piece_to_move` to the destination square, then pulses `move_complete`.
- Sits downstream of the game control FSM, which grants it the memory port (memory_manage = 2'b10) during its WAIT states.

Parameters:
- COORD_W, 3, width of one board coordinate.
- PIECE_W, 4, width of a piece code.
- ADDR_W, 6, memory address width; equals 2*COORD_W.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset.
- initialize_board  in  1  start-initialise strobe from control.
- move_piece  in  1  start-move strobe from control.
- piece_to_move  in  4  piece code to place at the destination.
- origin_x, origin_y  in  3 each  source square.
- destination_x, destination_y  in  3 each  target square.
- address  out  6  board memory address.
- data_out  out  4  board memory write data.
- write_enable  out  1  board memory write strobe.
- busy  out  1  high in any state other than S_IDLE.
- initialize_complete  out  1  one-cycle done pulse for initialisation.
- move_complete  out  1  one-cycle done pulse for a move.

Interface rule (decided): one clock, `clk`; `reset` is synchronous and active-high.

Behaviour:
- Address map: address = {y, x}; square (x,y) maps to y*8+x. (0,0) is the lower-left square, player 0's side.
- Piece codes: 0 empty.
  - Player 0: 1 pawn, 2 rook, 3 knight, 4 bishop, 5 queen, 6 king.
  - Player 1: code +6, i.e. 7..12, king = 12.
- Opening layout:
  - Row 0: 2,3,4,5,6,4,3,2 for x = 0..7.
  - Row 1: all 1.
  - Rows 2-5: all 0.
  - Row 6: all 7.
  - Row 7: 8,9,10,11,12,10,9,8.
- Reset: state S_IDLE. All outputs 0, counter 0.
- FSM states:
  - S_IDLE: outputs idle.
    - If initialize_board = 1, go to S_INIT and clear the counter.
    - Else if move_piece = 1, latch origin, destination and piece into internal registers, then go to S_MOVE_CLEAR.
    - initialize_board has priority when both strobes are high.
  - S_INIT: write_enable = 1, address = counter, data_out = ROM(counter). Counter increments each cycle. After writing address 63, go to S_INIT_DONE.
  - S_INIT_DONE: initialize_complete = 1 for one cycle, then S_IDLE.
  - S_MOVE_CLEAR: write_enable = 1, address = {origin_y, origin_x}, data_out = 0. Next state S_MOVE_PLACE.
  - S_MOVE_PLACE: write_enable = 1, address = {dest_y, dest_x}, data_out = latched piece. Next state S_MOVE_DONE.
  - S_MOVE_DONE: move_complete = 1 for one cycle, then S_IDLE.
- Latency, counted with the strobe sampled at cycle 0:
  - Init writes occur in cycles 1..64; initialize_complete pulses in cycle 65.
  - Move writes occur in cycles 1 and 2; move_complete pulses in cycle 3.
- Outputs are registered from state/counter or decoded directly from state. In non-writing states, address, data_out and write_enable are 0.
- Strobes arriving while busy = 1 are ignored and not queued.
- Move inputs are latched once in S_IDLE; changes afterwards have no effect.
- Origin == destination: the clear happens first and the place second, so the square ends holding piece_to_move.
- The counter is 6 bits; its terminal value is 63. It must not wrap to a second pass.
- Reset mid-operation: return to S_IDLE next cycle and deassert write_enable immediately on that edge. No done pulse is issued. Memory contents are left partially written.
- The block does not arbitrate the memory port. Control guarantees the grant is active during S_INIT..S_MOVE_DONE.

Decomposition:
- Shared package board_pkg holds:
  - The piece-code constants (EMPTY, P0_PAWN..P0_KING, P1_OFFSET = 6, P1_KING = 12).
  - BOARD_DIM = 8 and the address-composition function {y, x}.
  - The state encoding.
- One sub-module, board_init_rom: combinational, 6-bit address in, 4-bit opening piece out. Reused by the view for title rendering.

Test Plan:
- Init: pulse initialize_board for 1 cycle -> exactly 64 writes over addresses 0..63 in order:
  - addr 4 = 6, addr 60 = 12, addr 8..15 = 1, addr 16..47 = 0.
  - initialize_complete high in cycle 65 only.
- Move: piece 1, origin (4,1), destination (4,3) -> cycle 1 writes addr 12 with 0; cycle 2 writes addr 28 with 1; move_complete in cycle 3.
- Priority/busy: initialize_board and move_piece both high -> init sequence runs. A move_piece at init cycle 10 is ignored: no extra writes, and only initialize_complete pulses.
- Same square: origin = destination = (7,7), piece 8 -> addr 63 written 0, then addr 63 written 8.
- Reset mid-init at cycle 30 -> write_enable 0 from the next cycle, no initialize_complete, busy 0. A subsequent init runs all 64 writes again.
- Input change after latch: destination_x changed during S_MOVE_CLEAR -> the place write still uses the originally latched destination.

Source files
------------

// File: rtl/board_pkg.sv
// Shared definitions for the board datapath: geometry, piece codes,
// FSM state encoding and the square-address helper.
package board_pkg;

  localparam int COORD_W   = 3;
  localparam int PIECE_W   = 4;
  localparam int ADDR_W    = 2 * COORD_W;
  localparam int BOARD_DIM = 8;

  localparam logic [PIECE_W-1:0] EMPTY     = 4'd0;
  localparam logic [PIECE_W-1:0] P0_PAWN   = 4'd1;
  localparam logic [PIECE_W-1:0] P0_ROOK   = 4'd2;
  localparam logic [PIECE_W-1:0] P0_KNIGHT = 4'd3;
  localparam logic [PIECE_W-1:0] P0_BISHOP = 4'd4;
  localparam logic [PIECE_W-1:0] P0_QUEEN  = 4'd5;
  localparam logic [PIECE_W-1:0] P0_KING   = 4'd6;
  localparam logic [PIECE_W-1:0] P1_OFFSET = 4'd6;
  localparam logic [PIECE_W-1:0] P1_KING   = 4'd12;

  localparam logic [ADDR_W-1:0] LAST_SQUARE = ADDR_W'(BOARD_DIM * BOARD_DIM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_INIT_DONE,
    S_MOVE_CLEAR,
    S_MOVE_PLACE,
    S_MOVE_DONE
  } state_t;

  // Square (x,y) lives at y*8+x.
  function automatic logic [ADDR_W-1:0] square_addr(input logic [COORD_W-1:0] x,
                                                    input logic [COORD_W-1:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/board_init_rom.sv
// Opening-position lookup: square address in, starting piece code out.
module board_init_rom
  import board_pkg::*;
(
  input  logic [ADDR_W-1:0]  address,
  output logic [PIECE_W-1:0] piece
);

  logic [COORD_W-1:0] row;
  logic [COORD_W-1:0] col;
  logic [PIECE_W-1:0] back_rank;

  assign row = address[ADDR_W-1:COORD_W];
  assign col = address[COORD_W-1:0];

  // Player 0 back-rank piece for this column; player 1 mirrors it with an offset.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    back_rank = EMPTY;
    unique case (col)
      3'd0, 3'd7: back_rank = P0_ROOK;
      3'd1, 3'd6: back_rank = P0_KNIGHT;
      3'd2, 3'd5: back_rank = P0_BISHOP;
      3'd3:       back_rank = P0_QUEEN;
      3'd4:       back_rank = P0_KING;
      default:    back_rank = EMPTY;
    endcase
  end

  // Select the piece by row: back ranks, pawn ranks, empty middle.
  always_comb begin
    piece = EMPTY;
    unique case (row)
      3'd0:    piece = back_rank;
      3'd1:    piece = P0_PAWN;
      3'd6:    piece = P0_PAWN + P1_OFFSET;
      3'd7:    piece = back_rank + P1_OFFSET;
      default: piece = EMPTY;
    endcase
  end

endmodule

// File: rtl/board_datapath.sv
// Sole writer of the 64-square board memory: writes the opening layout on
// initialize_board and performs clear-then-place on move_piece.
module board_datapath
  import board_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               initialize_board,
  input  logic               move_piece,
  input  logic [PIECE_W-1:0] piece_to_move,
  input  logic [COORD_W-1:0] origin_x,
  input  logic [COORD_W-1:0] origin_y,
  input  logic [COORD_W-1:0] destination_x,
  input  logic [COORD_W-1:0] destination_y,
  output logic [ADDR_W-1:0]  address,
  output logic [PIECE_W-1:0] data_out,
  output logic               write_enable,
  output logic               busy,
  output logic               initialize_complete,
  output logic               move_complete
);

  state_t             state;
  logic [ADDR_W-1:0]  counter;
  logic [ADDR_W-1:0]  rom_addr;
  logic [PIECE_W-1:0] rom_piece;
  logic [COORD_W-1:0] dest_x_q;
  logic [COORD_W-1:0] dest_y_q;
  logic [PIECE_W-1:0] piece_q;

  // The ROM is looked up one square ahead so the registered write data
  // lines up with the registered address.
  always_comb begin
    rom_addr = '0;
    if (state == S_INIT) rom_addr = counter + 6'd1;
  end

  board_init_rom u_rom (
    .address (rom_addr),
    .piece   (rom_piece)
  );

  assign busy = (state != S_IDLE);

  // Control FSM with registered memory-port outputs and done pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= S_IDLE;
      counter             <= '0;
      dest_x_q            <= '0;
      dest_y_q            <= '0;
      piece_q             <= EMPTY;
      address             <= '0;
      data_out            <= EMPTY;
      write_enable        <= 1'b0;
      initialize_complete <= 1'b0;
      move_complete       <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every branch
      // below sees the pre-edge values; the defaults make the port idle unless
      // a state explicitly drives it.
      address             <= '0;
      data_out            <= EMPTY;
      write_enable        <= 1'b0;
      initialize_complete <= 1'b0;
      move_complete       <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (initialize_board) begin
            state        <= S_INIT;
            counter      <= '0;
            address      <= '0;
            data_out     <= P0_ROOK;
            write_enable <= 1'b1;
          end else if (move_piece) begin
            dest_x_q     <= destination_x;
            dest_y_q     <= destination_y;
            piece_q      <= piece_to_move;
            state        <= S_MOVE_CLEAR;
            address      <= square_addr(origin_x, origin_y);
            data_out     <= EMPTY;
            write_enable <= 1'b1;
          end
        end

        S_INIT: begin
          if (counter == LAST_SQUARE) begin
            state               <= S_INIT_DONE;
            initialize_complete <= 1'b1;
          end else begin
            counter      <= counter + 6'd1;
            address      <= counter + 6'd1;
            data_out     <= rom_piece;
            write_enable <= 1'b1;
          end
        end

        S_INIT_DONE: state <= S_IDLE;

        S_MOVE_CLEAR: begin
          state        <= S_MOVE_PLACE;
          address      <= square_addr(dest_x_q, dest_y_q);
          data_out     <= piece_q;
          write_enable <= 1'b1;
        end

        S_MOVE_PLACE: begin
          state         <= S_MOVE_DONE;
          move_complete <= 1'b1;
        end

        S_MOVE_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
